// File: rtl/psw_stack_pkg.sv
// Shared constants for the program-status register: SFR addresses, flag indices, ALU mask presets.
package psw_stack_pkg;

  localparam logic [7:0] SFR_PSW   = 8'hD0;
  localparam logic [4:0] SFR_B_PSW = 5'b11010;

  localparam int unsigned FLAG_CY  = 7;
  localparam int unsigned FLAG_AC  = 6;
  localparam int unsigned FLAG_F0  = 5;
  localparam int unsigned FLAG_RS1 = 4;
  localparam int unsigned FLAG_RS0 = 3;
  localparam int unsigned FLAG_OV  = 2;
  localparam int unsigned FLAG_F1  = 1;
  localparam int unsigned FLAG_P   = 0;

  localparam logic [7:0] MASK_CY       = 8'h80;
  localparam logic [7:0] MASK_CY_OV    = 8'h84;
  localparam logic [7:0] MASK_CY_OV_AC = 8'hC4;

endpackage

// File: rtl/status_lifo.sv
// WIDTH x DEPTH LIFO for saved status words; reports accepted push/pop and a misuse pulse.
module status_lifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic             pop_ok_o,
  output logic             err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok_o = push_i & ~pop_i & ~full_o;
  assign pop_ok_o  = pop_i & ~push_i & ~empty_o;
  // Simultaneous push/pop is treated as misuse and both are dropped.
  assign err_o     = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);
  assign count_o   = count_q;
  assign top_o     = mem_q[AW'(count_q - CW'(1))];

  always_comb begin
    count_d = count_q;
    if (push_ok_o) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_o) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_o) begin
      mem_q[AW'(count_q)] <= data_i;
    end
  end

endmodule

// File: rtl/psw_stack.sv
// Parametrised program-status register with priority update logic, live parity and shadow stack.
// Optional PSW_STACK_BANK_AUTO_EN: a valid push also clears the bank-select bits [4:3].
module psw_stack
  import psw_stack_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [7:0]       SFR_ADDR   = SFR_PSW,
  parameter logic [4:0]       BIT_BASE   = SFR_B_PSW,
  parameter int unsigned      PARITY_BIT = 0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter int unsigned      CW         = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [7:0]       addr,
  input  logic             write_en,
  input  logic             write_bit_en,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] flag_in,
  input  logic [WIDTH-1:0] flag_mask,
  input  logic [7:0]       acc,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] psw_data,
  output logic [CW-1:0]    depth_cnt,
  output logic             full,
  output logic             empty,
  output logic             stack_err
);

  localparam logic [WIDTH-1:0] PMASK = WIDTH'(1) << PARITY_BIT;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             stack_err_q;
  logic [WIDTH-1:0] lifo_top;
  logic             push_ok;
  logic             pop_ok;
  logic             lifo_err;
  logic             byte_wr;
  logic             bit_wr;
  logic             err_clr;
  logic [2:0]       bit_idx;
  logic [WIDTH-1:0] upd_mask;

  status_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .clk       (clock),
    .rst_n     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (data_q),
    .top_o     (lifo_top),
    .count_o   (depth_cnt),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok),
    .err_o     (lifo_err)
  );

  assign bit_idx  = addr[2:0];
  assign byte_wr  = write_en & ~write_bit_en & (addr == SFR_ADDR);
  assign err_clr  = write_en & ~write_bit_en & (addr == 8'(SFR_ADDR + 8'd1)) & data_in[0];
  assign bit_wr   = write_en & write_bit_en & (addr[7:3] == BIT_BASE)
                  & (32'(bit_idx) < WIDTH) & (32'(bit_idx) != PARITY_BIT);
  assign upd_mask = flag_mask & ~PMASK;

  // Stored parity bit is dead; the output always carries live accumulator parity.
  assign psw_data  = (data_q & ~PMASK) | ({WIDTH{^acc}} & PMASK);
  assign stack_err = stack_err_q;

  always_comb begin
    data_d = data_q;
    if (pop_ok) begin
      data_d = (lifo_top & ~PMASK) | (data_q & PMASK);
    end else if (byte_wr) begin
      data_d = (data_in & ~PMASK) | (data_q & PMASK);
    end else if (bit_wr) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i == 32'(bit_idx)) begin
          data_d[i] = bit_in;
        end
      end
    end else begin
      data_d = (data_q & ~upd_mask) | (flag_in & upd_mask);
    end
`ifdef PSW_STACK_BANK_AUTO_EN
    if (push_ok) begin
      data_d[4:3] = 2'b00;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q      <= RESET_VAL;
      stack_err_q <= 1'b0;
    end else begin
      data_q <= data_d;
      if (lifo_err) begin
        stack_err_q <= 1'b1;
      end else if (err_clr) begin
        stack_err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psw_stack.sv
// Self-checking bench for psw_stack: queue-based status model plus directed literal checks.
`timescale 1ns/1ps
module tb_psw_stack;
  import psw_stack_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PB    = 0;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in, addr, flag_in, flag_mask, acc;
  logic       write_en, write_bit_en, bit_in, push, pop;
  logic [7:0] psw_data;
  logic [2:0] depth_cnt;
  logic       full, empty, stack_err;

  int checks = 0;
  int errors = 0;

  psw_stack #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .addr(addr),
    .write_en(write_en), .write_bit_en(write_bit_en), .bit_in(bit_in),
    .flag_in(flag_in), .flag_mask(flag_mask), .acc(acc), .push(push), .pop(pop),
    .psw_data(psw_data), .depth_cnt(depth_cnt), .full(full), .empty(empty),
    .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: status word plus a queue of saved words.
  logic [7:0] m_data;
  logic [7:0] m_q[$];
  logic       m_err;
  bit         started = 0;

  always @(posedge clock) begin
    logic [7:0] nd;
    logic [7:0] old;
    bit vpush, vpop, misuse;
    if (!reset) begin
      m_data = 8'h00;
      m_q.delete();
      m_err = 1'b0;
      started = 1;
    end else begin
      old    = m_data;
      vpush  = push && !pop && (m_q.size() < DEPTH);
      vpop   = pop && !push && (m_q.size() > 0);
      misuse = (push && pop) || (push && m_q.size() == DEPTH) || (pop && m_q.size() == 0);
      nd = old;
      if (vpop) nd = m_q.pop_back();
      else if (write_en && !write_bit_en && addr == 8'hD0) nd = data_in;
      else if (write_en && write_bit_en && addr[7:3] == 5'b11010) begin
        if (addr[2:0] != 3'(PB)) nd[addr[2:0]] = bit_in;
      end else begin
        for (int i = 0; i < 8; i++) if (flag_mask[i]) nd[i] = flag_in[i];
      end
      if (vpush) m_q.push_back(old);
`ifdef PSW_STACK_BANK_AUTO_EN
      if (vpush) nd[4:3] = 2'b00;
`endif
      nd[PB] = old[PB];
      m_data = nd;
      if (misuse) m_err = 1'b1;
      else if (write_en && !write_bit_en && addr == 8'hD1 && data_in[0]) m_err = 1'b0;
    end
  end

  function automatic logic [7:0] exp_psw(input logic [7:0] d, input logic [7:0] a);
    logic [7:0] r;
    r = d;
    r[PB] = ^a;
    return r;
  endfunction

  always @(negedge clock) begin
    if (started) begin
      chk("cmp_psw",   psw_data,  exp_psw(m_data, acc));
      chk("cmp_depth", depth_cnt, m_q.size());
      chk("cmp_full",  full,      m_q.size() == DEPTH);
      chk("cmp_empty", empty,     m_q.size() == 0);
      chk("cmp_err",   stack_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_en = 0; write_bit_en = 0; bit_in = 0; push = 0; pop = 0;
    flag_mask = 8'h00; flag_in = 8'h00; data_in = 8'h00; addr = 8'h00;
  endtask

  task automatic byte_wr(input logic [7:0] a, input logic [7:0] d);
    write_en = 1; write_bit_en = 0; addr = a; data_in = d;
  endtask

  initial begin
    idle();
    acc = 8'h00;
    reset = 0;
    tick();
    chk("reset_psw", psw_data, 8'h00);
    chk("reset_empty", empty, 1'b1);
    chk("reset_depth", depth_cnt, 3'd0);
    chk("reset_err", stack_err, 1'b0);
    reset = 1;

    // Masked ALU flag update
    flag_in = 8'hFF; flag_mask = MASK_CY_OV; acc = 8'h03;
    tick();
    chk("flag_upd", psw_data, 8'h84);

    // Byte write beats flag update, then bit write CY
    idle(); byte_wr(8'hD0, 8'h18); flag_in = 8'hFF; flag_mask = 8'hFF;
    tick();
    chk("byte_prio", psw_data, 8'h18);
    idle(); write_en = 1; write_bit_en = 1; addr = 8'hD7; bit_in = 1;
    tick();
    chk("bit_wr", psw_data, 8'h98);

    // Stack round trip
    idle(); push = 1;
    tick();
    chk("rt_depth1", depth_cnt, 3'd1);
    idle(); byte_wr(8'hD0, 8'h00);
    tick();
    chk("rt_clobber", psw_data, 8'h00);
    chk("rt_depth1b", depth_cnt, 3'd1);
    idle(); pop = 1; acc = 8'h01;
    tick();
    chk("rt_restore", psw_data, 8'h99);
    chk("rt_depth0", depth_cnt, 3'd0);

    // Overflow
    idle(); acc = 8'h00; push = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("ovf_depth", depth_cnt, 3'd4);
    chk("ovf_full", full, 1'b1);
    chk("ovf_err", stack_err, 1'b1);
    idle(); byte_wr(8'hD1, 8'h01);
    tick();
    chk("err_clear", stack_err, 1'b0);

    // Underflow
    idle(); pop = 1;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("unf_empty", empty, 1'b1);
    chk("unf_noerr", stack_err, 1'b0);
    tick();
    chk("unf_err", stack_err, 1'b1);
    chk("unf_depth", depth_cnt, 3'd0);

    // Simultaneous push/pop at depth 2: stack untouched, write still lands
    idle(); byte_wr(8'hD1, 8'h01);
    tick();
    idle(); push = 1;
    tick(); tick();
    idle(); push = 1; pop = 1; byte_wr(8'hD0, 8'h5A);
    tick();
    chk("pp_depth", depth_cnt, 3'd2);
    chk("pp_err", stack_err, 1'b1);
    chk("pp_write", psw_data, 8'h5A);

    // Ignored bit writes (parity index, wrong base), then flags on unrelated byte write
    idle(); write_en = 1; write_bit_en = 1; addr = 8'hD0; bit_in = 1;
    tick();
    idle(); write_en = 1; write_bit_en = 1; addr = 8'hC3; bit_in = 1;
    tick();
    chk("bit_ignored", psw_data, 8'h5A);
    idle(); byte_wr(8'hD5, 8'hFF); flag_in = 8'h80; flag_mask = MASK_CY;
    tick();
    chk("flag_other_addr", psw_data, 8'hDA);

    // Bank select behaviour on push/pop
    idle(); byte_wr(8'hD0, 8'h18);
    tick();
    idle(); push = 1;
    tick();
`ifdef PSW_STACK_BANK_AUTO_EN
    chk("bank_push", {psw_data[FLAG_RS1], psw_data[FLAG_RS0]}, 2'b00);
`else
    chk("bank_push", {psw_data[FLAG_RS1], psw_data[FLAG_RS0]}, 2'b11);
`endif
    chk("bank_depth", depth_cnt, 3'd3);
    idle(); pop = 1;
    tick();
    chk("bank_pop", psw_data, 8'h18);

    // Reset with a non-empty stack
    idle(); reset = 0;
    tick();
    chk("rst2_psw", psw_data, 8'h00);
    chk("rst2_depth", depth_cnt, 3'd0);
    chk("rst2_err", stack_err, 1'b0);
    reset = 1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psw_stack.md
Name: psw_stack

Overview:
- Parametrised program-status register, successor to the fixed 8-bit PSW.
- Generalised width, configurable SFR byte and bit addresses, and per-flag ALU update masks instead of fixed flag-set codes.
- Adds a hardware shadow stack that saves and restores status on interrupt entry (push) and RETI (pop).
- Sits beside the ALU and SFR bus; its output feeds register-bank select and conditional-branch logic.

Parameters:
- WIDTH, 8, status register width in bits.
- DEPTH, 4, shadow-stack entries (≥1).
- SFR_ADDR, 8'hD0, byte address for SFR writes.
- BIT_BASE, 5'b11010, addr[7:3] match for bit-addressed writes.
- PARITY_BIT, 0, bit index replaced by live accumulator parity.
- RESET_VAL, 0, register value after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; register and stack are reset when reset=0 at a clock edge.
- data_in  in  WIDTH  byte-write data.
- addr  in  8  SFR / bit address.
- write_en  in  1  SFR write strobe.
- write_bit_en  in  1  qualifies write_en as a bit write.
- bit_in  in  1  bit-write value.
- flag_in  in  WIDTH  ALU flag results.
- flag_mask  in  WIDTH  per-bit ALU update enable.
- acc  in  8  accumulator, used for parity.
- push  in  1  save status (interrupt entry).
- pop  in  1  restore status (RETI).
- psw_data  out  WIDTH  status output.
- depth_cnt  out  $clog2(DEPTH+1)  occupied stack entries.
- full  out  1  depth_cnt==DEPTH.
- empty  out  1  depth_cnt==0.
- stack_err  out  1  sticky misuse flag.

Behaviour:
- Reset (reset=0 at clock edge):
  - data=RESET_VAL, depth_cnt=0, empty=1, full=0, stack_err=0.
  - Stack contents are don't-care.
- psw_data is combinational: data with bit PARITY_BIT replaced by even parity ^acc. The stored value of PARITY_BIT is never written and never read.
- Register update priority per cycle, highest first:
  1. pop (valid): data <= stack[top], except PARITY_BIT; all writes and flag updates that cycle are discarded.
  2. Byte write, when write_en & !write_bit_en & addr==SFR_ADDR: data <= data_in, except PARITY_BIT.
  3. Bit write, when write_en & write_bit_en & addr[7:3]==BIT_BASE & addr[2:0]<WIDTH: data[addr[2:0]] <= bit_in. The write is ignored if the index is PARITY_BIT.
  4. Flag update: for each i with flag_mask[i]=1, data[i] <= flag_in[i]. The update applies only when neither 2 nor 3 fired.
- Push (valid): stack[depth_cnt] <= pre-edge data, and depth_cnt increments. A same-cycle write or flag update still lands in data, so the saved value is the old status.
- Pop (valid): depth_cnt decrements, and the restored value appears on psw_data the cycle after the edge.
- Push when full: ignored, stack_err <= 1.
- Pop when empty: ignored, stack_err <= 1.
- Push and pop in the same cycle: both ignored, stack_err <= 1; rule 1 does not apply, so writes and flag updates proceed.
- stack_err clears only on reset, or on a byte write to SFR_ADDR+1 with data_in[0]=1.
- full and empty are combinational from depth_cnt. Latency of every write is 1 cycle.

Optional Feature:
- Macro PSW_STACK_BANK_AUTO_EN.
- When defined: a valid push also clears data[4:3] (register-bank select) in the same edge, so the ISR enters on bank 0. Pop restores the saved bank. This requires WIDTH≥5.
- When undefined: push leaves data unchanged.

Decomposition:
- Shared package/include file holds:
  - SFR_PSW and SFR_B_PSW address constants;
  - flag index constants (CY=7, AC=6, F0=5, RS1=4, RS0=3, OV=2, F1=1, P=0);
  - standard flag_mask presets (CY, CY|OV, CY|OV|AC).
- One natural sub-module, status_lifo: parametrised WIDTH×DEPTH LIFO with push/pop/count/full/empty and error pulse. psw_stack wraps it with the priority and parity logic.

Test Plan:
- Reset: drive reset=0 for one edge → psw_data=8'h00 with acc=0; empty=1, depth_cnt=0.
- Masked flag update: flag_in=8'hFF, flag_mask=8'h84, acc=8'h03 → psw_data=8'h84 (CY, OV set; parity=0).
- Byte-write priority: byte write data_in=8'h18 to 8'hD0 in the same cycle as flag_mask=8'hFF → data=8'h18. Then bit write addr=8'hD7, bit_in=1 → 8'h98.
- Stack round-trip: push with data=8'h98, then write 8'h00, then pop → psw_data returns to 8'h98 (8'h99 when acc=8'h01); depth_cnt goes 1→1→0.
- Full/empty errors: DEPTH+1 pushes → 5th ignored, full=1, stack_err=1. Clear via write 8'h01 to 8'hD1, then pop on empty → stack_err=1 again.
- Simultaneous/optional cases:
  - push and pop together with depth 2 → depth stays 2, stack_err=1.
  - With PSW_STACK_BANK_AUTO_EN and data=8'h18: push → psw_data[4:3]=0; pop → 2'b11.
